n64adv2_joybus_sniffer: RTL

Multi-port, parametrised joybus sniffer in the CTRL_CLK domain. Passively decodes N64-to-controller commands and controller responses on up to four joybus lines. Publishes button frames and device-type words per port with a toggle-acknowledge handshake toward the NIOS side. Optionally detects an in-game-reset combo held over several polls.

---
 rtl/n64adv2_joybus_sniffer_pkg.sv | 28 ++
 rtl/n64adv2_joybus_port.sv | 124 ++++++++++++
 rtl/n64adv2_joybus_sniffer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/n64adv2_joybus_sniffer_pkg.sv
// Shared joybus definitions for the sniffer: command codes, response
// lengths, FSM state encoding, the in-game-reset button combo and a
// bit-reverse helper used to put button frames in receive order.
package n64adv2_joybus_sniffer_pkg;

  localparam logic [7:0]  CMD_STATUS  = 8'h00;
  localparam logic [7:0]  CMD_BUTTONS = 8'h01;
  localparam logic [7:0]  CMD_RESET   = 8'hFF;

  localparam int          LEN_STATUS  = 24;
  localparam int          LEN_BUTTONS = 32;

  // A + B + Z + Start + L + R (bit i = i-th received button bit)
  localparam logic [15:0] IGR_RESET   = 16'h0C0F;

  typedef enum logic [1:0] {
    WAIT4N64 = 2'd0,
    N64_RD   = 2'd1,
    CTRL_RD  = 2'd2
  } jb_state_e;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/n64adv2_joybus_port.sv
// One sniffed joybus line: synchroniser/edge history, bit-timing counter,
// decode FSM and shift register.
// Ports:
//   CTRL_CLK, CTRL_RST  clock, synchronous active-high reset
//   ctrl_i              raw joybus line (asynchronous)
//   en_i                port enable; low holds the FSM idle
//   done_o              one-cycle pulse on the final decoding negedge
//   btn_o               frame kind of done_o: 1 = button, 0 = status
//   data_o              button frame, bit i = i-th received bit (valid with done_o)
//   dev_o               status device type, first bit at MSB (valid with done_o)
//   tout_o              one-cycle pulse: timeout inside a frame
module n64adv2_joybus_port
  import n64adv2_joybus_sniffer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic        CTRL_CLK,
  input  logic        CTRL_RST,
  input  logic        ctrl_i,
  input  logic        en_i,
  output logic        done_o,
  output logic        btn_o,
  output logic [31:0] data_o,
  output logic [15:0] dev_o,
  output logic        tout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  jb_state_e        state_q, state_n;
  logic [2:0]       hist;
  logic [CNT_W-1:0] cnt, low_cnt;
  logic [30:0]      sr;
  logic [5:0]       bit_cnt;
  logic             btn_q;
  logic             nedge, pedge, sat, bit_w, last_bit;
  logic [31:0]      new_sr;

  // hist[1:0] double as the two synchroniser stages; hist[2] is the
  // previous synchronised value used for edge detection.
  assign nedge    = hist[2] & ~hist[1];
  assign pedge    = ~hist[2] & hist[1];
  assign sat      = (cnt == CNT_MAX);
  // low phase shorter than high phase -> 1; a tie decodes as 0
  assign bit_w    = (low_cnt < cnt);
  assign new_sr   = {sr, bit_w};
  assign last_bit = (bit_cnt == (btn_q ? 6'(LEN_BUTTONS-1) : 6'(LEN_STATUS-1)));

  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) begin
      hist    <= 3'b111;
      cnt     <= '0;
      low_cnt <= '0;
    end else begin
      hist <= {hist[1:0], ctrl_i};
      if (nedge || pedge) cnt <= '0;
      else if (!sat)      cnt <= cnt + 1'b1;
      if (pedge) low_cnt <= cnt;
    end
  end

  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) state_q <= WAIT4N64;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      WAIT4N64: if (nedge && sat) state_n = N64_RD;
      // 9th negedge ends the N64 stop bit: the command is complete in sr[7:0]
      N64_RD: begin
        if (sat) state_n = WAIT4N64;
        else if (nedge && bit_cnt == 6'd8)
          state_n = (sr[7:0] inside {CMD_STATUS, CMD_BUTTONS, CMD_RESET}) ? CTRL_RD : WAIT4N64;
      end
      CTRL_RD: begin
        if (sat)                    state_n = WAIT4N64;
        else if (nedge && last_bit) state_n = WAIT4N64;
      end
      default: state_n = WAIT4N64;
    endcase
    if (!en_i) state_n = WAIT4N64;
  end

  always_comb begin
    done_o = 1'b0;
    tout_o = 1'b0;
    if (en_i) begin
      case (state_q)
        N64_RD:  tout_o = sat && (bit_cnt != 6'd0);
        CTRL_RD: begin
          tout_o = sat;
          done_o = !sat && nedge && last_bit;
        end
        default: ;
      endcase
    end
  end

  assign btn_o  = btn_q;
  assign data_o = bit_rev32(new_sr);
  assign dev_o  = new_sr[23:8];

  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) begin
      sr      <= '0;
      bit_cnt <= '0;
      btn_q   <= 1'b0;
    end else if (state_q == WAIT4N64 && state_n == N64_RD) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (state_q == N64_RD && state_n == CTRL_RD) begin
      sr      <= '0;
      bit_cnt <= '0;
      btn_q   <= (sr[7:0] == CMD_BUTTONS);
    end else if (nedge && !sat &&
                 ((state_q == N64_RD && bit_cnt < 6'd8) || state_q == CTRL_RD)) begin
      sr      <= new_sr[30:0];
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/n64adv2_joybus_sniffer.sv
// Passive multi-port joybus sniffer. Publishes button frames and status
// device types per port with a toggle-acknowledge handshake.
// Optional feature macro: N64ADV2_JOYBUS_IGR_EN (in-game-reset combo detect).
// Ports:
//   CTRL_CLK, CTRL_RST  clock, synchronous active-high reset
//   CTRL_i              raw joybus lines
//   port_en_i           per-port enable
//   data_tack_i         per-port acknowledge toggle
//   use_igr_i           IGR detection enable
//   ctrl_data_o         last button frame per port (32 bits each)
//   dev_type_o          last device type per port (16 bits each)
//   new_data_o          unacknowledged button frame pending
//   err_o               sticky timeout/overrun flag
//   igr_req_o           one-cycle IGR request
module n64adv2_joybus_sniffer
  import n64adv2_joybus_sniffer_pkg::*;
#(
  parameter int NUM_PORTS = 1,
  parameter int CNT_W     = 8,
  parameter int IGR_HOLD  = 4
) (
  input  logic                     CTRL_CLK,
  input  logic                     CTRL_RST,
  input  logic [NUM_PORTS-1:0]     CTRL_i,
  input  logic [NUM_PORTS-1:0]     port_en_i,
  input  logic [NUM_PORTS-1:0]     data_tack_i,
  input  logic                     use_igr_i,
  output logic [32*NUM_PORTS-1:0]  ctrl_data_o,
  output logic [16*NUM_PORTS-1:0]  dev_type_o,
  output logic [NUM_PORTS-1:0]     new_data_o,
  output logic [NUM_PORTS-1:0]     err_o,
  output logic                     igr_req_o
);

  logic [NUM_PORTS-1:0] tack_q, tack_tgl;

  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) tack_q <= '0;
    else          tack_q <= data_tack_i;
  end
  assign tack_tgl = tack_q ^ data_tack_i;

`ifdef N64ADV2_JOYBUS_IGR_EN
  logic [NUM_PORTS-1:0] trig, win;

  // only the lowest triggering port consumes its hold count
  always_comb begin
    logic found;
    found = 1'b0;
    win   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      win[p] = trig[p] & ~found;
      found  = found | trig[p];
    end
  end

  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) igr_req_o <= 1'b0;
    else          igr_req_o <= |trig;
  end
`else
  logic unused_igr;
  assign unused_igr = use_igr_i;
  assign igr_req_o  = 1'b0;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic        done, btn, tout;
    logic [31:0] data, latch_q, ctrl_q;
    logic [15:0] dev, dev_q;
    logic        pend_q, nd_q, err_q;

    n64adv2_joybus_port #(.CNT_W(CNT_W)) u_port (
      .CTRL_CLK (CTRL_CLK),
      .CTRL_RST (CTRL_RST),
      .ctrl_i   (CTRL_i[p]),
      .en_i     (port_en_i[p]),
      .done_o   (done),
      .btn_o    (btn),
      .data_o   (data),
      .dev_o    (dev),
      .tout_o   (tout)
    );

    // button frame parks in latch_q for one cycle before publishing
    always_ff @(posedge CTRL_CLK) begin
      if (CTRL_RST) begin
        latch_q <= '0;
        pend_q  <= 1'b0;
        ctrl_q  <= '0;
        dev_q   <= '0;
        nd_q    <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        pend_q <= done & btn;
        if (done & btn)  latch_q <= data;
        if (done & ~btn) dev_q   <= dev;
        if (pend_q)      ctrl_q  <= latch_q;
        // set beats acknowledge
        if (pend_q)           nd_q <= 1'b1;
        else if (tack_tgl[p]) nd_q <= 1'b0;
        if (tout | (pend_q & nd_q)) err_q <= 1'b1;
        else if (tack_tgl[p])       err_q <= 1'b0;
      end
    end

    assign ctrl_data_o[32*p +: 32] = ctrl_q;
    assign dev_type_o[16*p +: 16]  = dev_q;
    assign new_data_o[p]           = nd_q;
    assign err_o[p]                = err_q;

`ifdef N64ADV2_JOYBUS_IGR_EN
    logic [3:0] hold_q, hold_nx;
    logic       combo;

    assign combo = (latch_q[15:0] == IGR_RESET);

    always_comb begin
      hold_nx = hold_q;
      if (pend_q) hold_nx = combo ? ((hold_q == 4'hF) ? hold_q : hold_q + 4'd1) : 4'd0;
    end

    assign trig[p] = use_igr_i && pend_q && combo && (hold_nx >= 4'(IGR_HOLD));

    always_ff @(posedge CTRL_CLK) begin
      if (CTRL_RST)    hold_q <= '0;
      else if (win[p]) hold_q <= '0;
      else             hold_q <= hold_nx;
    end
`endif
  end

endmodule
